instruction_fetch: RTL and testbench

- IF stage of the 5-stage MIPS pipeline, upstream of instruction decode.
- Holds the PC and a loadable instruction memory, and drives the IF/ID register (instruction, PC+4) into decode.
- Consumes decode's jump request (taken flag, byte target address) and the hazard unit's stall.
- Debug unit loads the program through a write port before the run starts.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/instruction_memory.sv | 34 +++
 rtl/instruction_fetch.sv | 158 +++++++++++++++
 tb/tb_instruction_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mips_pkg
//  Purpose : Shared constants and FSM encoding for the MIPS instruction
//            fetch stage (NOP/HALT words, PC increment, fetch states).
//  Rev     : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam int          PC_INC    = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
//  Module  : instruction_memory
//  Purpose : Word-addressed program memory, one synchronous write port and
//            one asynchronous read port. Contents are not reset.
//  Ports   : clk                    clock
//            we / waddr / wdata     synchronous write port
//            raddr / rdata          asynchronous read port
//  Rev     : 1.0  initial release
// ============================================================================
module instruction_memory #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [NB_ADDR-1:0] waddr,
    input  logic [NB_DATA-1:0] wdata,
    input  logic [NB_ADDR-1:0] raddr,
    output logic [NB_DATA-1:0] rdata
);

    logic [NB_DATA-1:0] mem [2**NB_ADDR];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module  : instruction_fetch
//  Purpose : IF stage of the 5-stage MIPS pipeline. Holds the PC and a
//            loadable instruction memory and drives the IF/ID register.
//            FSM: LOAD (program load) -> RUN (fetch) -> HALT (frozen).
//  Config  : IF_DELAY_SLOT_EN - when defined, a taken jump latches the
//            delay-slot instruction into IF/ID instead of flushing it.
//  Ports   : clk, i_rst_n (async, active-low)
//            i_enable       run/step enable, 0 freezes all state
//            i_stall        hazard stall, holds PC and IF/ID
//            i_jump         taken jump, i_jump_addr byte target
//            i_load_we/i_load_addr/i_load_data  program-load write port
//            i_start        leave LOAD and begin execution
//            o_instruction, o_pcounter4  IF/ID register
//            o_pc           current PC, o_halt program halted
//  Rev     : 1.0  initial release
// ============================================================================
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int NB_DATA      = 32,
    parameter int NB_IMEM_ADDR = 8
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_stall,
    input  logic                    i_jump,
    input  logic [NB_DATA-1:0]      i_jump_addr,
    input  logic                    i_load_we,
    input  logic [NB_IMEM_ADDR-1:0] i_load_addr,
    input  logic [NB_DATA-1:0]      i_load_data,
    input  logic                    i_start,
    output logic [NB_DATA-1:0]      o_instruction,
    output logic [NB_DATA-1:0]      o_pcounter4,
    output logic [NB_DATA-1:0]      o_pc,
    output logic                    o_halt
);

    localparam logic [NB_DATA-1:0] NOP  = NB_DATA'(NOP_WORD);
    localparam logic [NB_DATA-1:0] HWRD = NB_DATA'(HALT_WORD);
    localparam logic [NB_DATA-1:0] INC  = NB_DATA'(PC_INC);

    fetch_state_t       state, state_nx;
    logic [NB_DATA-1:0] pc, pc_nx;
    logic [NB_DATA-1:0] instr, instr_nx;
    logic [NB_DATA-1:0] pc4, pc4_nx;
    logic               halt, halt_nx;
    logic               mem_we;
    logic [NB_DATA-1:0] fetched;
    logic [NB_DATA-1:0] pc_plus4;
    logic [NB_DATA-1:0] jump_target;

    // Jump targets are word aligned; the two byte-offset bits are dropped.
    logic unused_jump_lsbs;
    assign unused_jump_lsbs = ^i_jump_addr[1:0];

    assign pc_plus4    = pc + INC;
    assign jump_target = {i_jump_addr[NB_DATA-1:2], 2'b00};

    // Upper PC bits are ignored by the index, so the PC wraps on the depth.
    instruction_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_IMEM_ADDR)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (i_load_addr),
        .wdata (i_load_data),
        .raddr (pc[NB_IMEM_ADDR+1:2]),
        .rdata (fetched)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= LOAD;
            pc    <= '0;
            instr <= NOP;
            pc4   <= '0;
            halt  <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            instr <= instr_nx;
            pc4   <= pc4_nx;
            halt  <= halt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = instr;
        pc4_nx   = pc4;
        halt_nx  = halt;
        mem_we   = 1'b0;

        if (i_enable) begin
            case (state)
                LOAD: begin
                    mem_we   = i_load_we;
                    pc_nx    = '0;
                    instr_nx = NOP;
                    pc4_nx   = '0;
                    if (i_start) begin
                        state_nx = RUN;
                    end
                end
                RUN: begin
                    if (i_stall) begin
                        // Hold everything; decode re-asserts any jump later.
                    end else if (i_jump) begin
                        pc_nx = jump_target;
`ifdef IF_DELAY_SLOT_EN
                        // Delay slot executes; a HALT there still stops the run.
                        if (fetched == HWRD) begin
                            instr_nx = NOP;
                            pc4_nx   = '0;
                            state_nx = HALT;
                        end else begin
                            instr_nx = fetched;
                            pc4_nx   = pc_plus4;
                        end
`else
                        // Flush the wrong-path fetch (including a HALT word).
                        instr_nx = NOP;
                        pc4_nx   = '0;
`endif
                    end else if (fetched == HWRD) begin
                        instr_nx = NOP;
                        pc4_nx   = '0;
                        state_nx = HALT;
                    end else begin
                        instr_nx = fetched;
                        pc4_nx   = pc_plus4;
                        pc_nx    = pc_plus4;
                    end
                end
                HALT: begin
                    instr_nx = NOP;
                    pc4_nx   = '0;
                    halt_nx  = 1'b1;
                end
                default: begin
                    state_nx = LOAD;
                end
            endcase
        end
    end

    assign o_instruction = instr;
    assign o_pcounter4   = pc4;
    assign o_pc          = pc;
    assign o_halt        = halt;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_instruction_fetch
//  Purpose : Directed, table-driven bench for instruction_fetch.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        enable, stall, jump, load_we, start;
    logic [31:0] jump_addr, load_data;
    logic [7:0]  load_addr;
    logic [31:0] instruction, pcounter4, pc;
    logic        halt;

    int checks = 0;
    int errors = 0;

    instruction_fetch #(
        .NB_DATA      (32),
        .NB_IMEM_ADDR (8)
    ) dut (
        .clk           (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_stall       (stall),
        .i_jump        (jump),
        .i_jump_addr   (jump_addr),
        .i_load_we     (load_we),
        .i_load_addr   (load_addr),
        .i_load_data   (load_data),
        .i_start       (start),
        .o_instruction (instruction),
        .o_pcounter4   (pcounter4),
        .o_pc          (pc),
        .o_halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        stall;
        logic        jump;
        logic        we;
        logic [31:0] addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt [15];

    // Program image used by the bench (word 3 changes between phases).
    function automatic logic [31:0] m(input int i);
        case (i)
            0:       m = 32'h2001_0005;
            1:       m = 32'h2002_0007;
            2:       m = 32'h0022_1820;
            3:       m = 32'h3030_3030;
            default: m = 32'h1000_0000 + 32'(i);
        endcase
    endfunction

    function automatic vec_t mk(input logic en, input logic st, input logic jp,
                                input logic we, input logic [31:0] addr,
                                input logic [31:0] ei, input logic [31:0] e4,
                                input logic [31:0] ep);
        vec_t v;
        v.en = en; v.stall = st; v.jump = jp; v.we = we; v.addr = addr;
        v.e_instr = ei; v.e_pc4 = e4; v.e_pc = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; stall = 1'b0; jump = 1'b0; load_we = 1'b0;
        start = 1'b0; jump_addr = '0; load_data = '0; load_addr = '0;

        // Expected results of the run table (starts in RUN at pc=0).
        vt[0]  = mk(1, 0, 0, 0, 32'h0,   m(0), 32'h04, 32'h04);
        vt[1]  = mk(1, 1, 0, 0, 32'h0,   m(0), 32'h04, 32'h04);
        vt[2]  = mk(1, 1, 0, 0, 32'h0,   m(0), 32'h04, 32'h04);
        vt[3]  = mk(1, 0, 0, 0, 32'h0,   m(1), 32'h08, 32'h08);
`ifdef IF_DELAY_SLOT_EN
        vt[4]  = mk(1, 0, 1, 0, 32'h20,  m(2), 32'h0C, 32'h20);
`else
        vt[4]  = mk(1, 0, 1, 0, 32'h20,  0,    0,      32'h20);
`endif
        vt[5]  = mk(1, 0, 0, 0, 32'h0,   m(8), 32'h24, 32'h24);
        vt[6]  = mk(1, 1, 1, 0, 32'h40,  m(8), 32'h24, 32'h24);
`ifdef IF_DELAY_SLOT_EN
        vt[7]  = mk(1, 0, 1, 0, 32'h13,  m(9), 32'h28, 32'h10);
`else
        vt[7]  = mk(1, 0, 1, 0, 32'h13,  0,    0,      32'h10);
`endif
        vt[8]  = mk(1, 0, 0, 0, 32'h0,   m(4), 32'h14, 32'h14);
        vt[9]  = mk(0, 0, 1, 0, 32'h80,  m(4), 32'h14, 32'h14);
        vt[10] = mk(0, 0, 0, 1, 32'h0,   m(4), 32'h14, 32'h14);
        vt[11] = mk(1, 0, 0, 1, 32'h0,   m(5), 32'h18, 32'h18);
        vt[12] = mk(1, 0, 0, 0, 32'h0,   m(6), 32'h1C, 32'h1C);
`ifdef IF_DELAY_SLOT_EN
        vt[13] = mk(1, 0, 1, 0, 32'h400, m(7), 32'h20, 32'h400);
`else
        vt[13] = mk(1, 0, 1, 0, 32'h400, 0,    0,      32'h400);
`endif
        vt[14] = mk(1, 0, 0, 0, 32'h0,   m(0), 32'h404, 32'h404);

        // Reset state.
        #12;
        check("rst_instr", instruction, 32'h0);
        check("rst_pc4",   pcounter4,   32'h0);
        check("rst_pc",    pc,          32'h0);
        check("rst_halt",  32'(halt),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load program words (word 3 comes later, with i_start).
        for (int i = 0; i < 64; i++) begin
            if (i != 3) begin
                load_we = 1'b1; load_addr = 8'(i); load_data = m(i);
                step();
            end
        end
        load_we = 1'b0;

        // Disabled: a pending start must not take effect.
        enable = 1'b0; start = 1'b1;
        step();
        enable = 1'b1; start = 1'b0;
        step();
        check("load_hold_instr", instruction, 32'h0);
        check("load_hold_pc",    pc,          32'h0);

        // Start together with the final write (HALT at word 3).
        load_we = 1'b1; load_addr = 8'd3; load_data = 32'hFFFF_FFFF; start = 1'b1;
        step();
        load_we = 1'b0; start = 1'b0;
        check("start_instr_nop", instruction, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("run_instr", instruction, m(k));
            check("run_pc4",   pcounter4,   32'(4 * (k + 1)));
            check("run_pc",    pc,          32'(4 * (k + 1)));
        end
        step();
        check("halt_fetch_nop", instruction, 32'h0);
        check("halt_fetch_pc",  pc,          32'h0C);
        step();
        step();
        check("halt_flag",   32'(halt),   32'h1);
        check("halt_pc",     pc,          32'h0C);
        check("halt_instr",  instruction, 32'h0);

        // HALT word fetched together with a taken jump.
        reset_pulse();
        check("rst_from_halt", 32'(halt), 32'h0);
        start_run();
        step(); step(); step();
        check("pre_jump_pc", pc, 32'h0C);
        jump = 1'b1; jump_addr = 32'h20;
        step();
        jump = 1'b0;
        check("hj_instr", instruction, 32'h0);
        check("hj_pc",    pc,          32'h20);
        step();
`ifdef IF_DELAY_SLOT_EN
        check("hj_next_instr", instruction, 32'h0);
        check("hj_next_pc",    pc,          32'h20);
`else
        check("hj_next_instr", instruction, m(8));
        check("hj_next_pc4",   pcounter4,   32'h24);
`endif

        // Reset mid-run at pc=0x08; program is retained.
        reset_pulse();
        start_run();
        step(); step();
        check("mid_pc", pc, 32'h08);
        rst_n = 1'b0;
        #1;
        check("mid_rst_instr", instruction, 32'h0);
        check("mid_rst_pc4",   pcounter4,   32'h0);
        check("mid_rst_pc",    pc,          32'h0);
        check("mid_rst_halt",  32'(halt),   32'h0);
        rst_n = 1'b1;
        start_run();
        step();
        check("restart_instr", instruction, m(0));
        check("restart_pc4",   pcounter4,   32'h04);

        // Replace the HALT word and run the vector table.
        reset_pulse();
        load_we = 1'b1; load_addr = 8'd3; load_data = m(3); start = 1'b1;
        step();
        load_we = 1'b0; start = 1'b0;
        load_addr = 8'd0; load_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 15; i++) begin
            enable = vt[i].en; stall = vt[i].stall; jump = vt[i].jump;
            load_we = vt[i].we; jump_addr = vt[i].addr;
            step();
            check($sformatf("vec%0d_instr", i), instruction, vt[i].e_instr);
            check($sformatf("vec%0d_pc4", i),   pcounter4,   vt[i].e_pc4);
            check($sformatf("vec%0d_pc", i),    pc,          vt[i].e_pc);
        end
        enable = 1'b1; stall = 1'b0; jump = 1'b0; load_we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
